// File: rtl/atan2_cordic_sn.sv
// Iterative CORDIC vectoring engine: sign-magnitude Q12.12 (x, y) -> atan2 angle, optional magnitude.
// Define ATAN2_MAG_OUT_EN to build the POST state and 1/K multiplier driving o_mag / o_overflow.

module atan2_cordic_sn #(
  parameter int N    = 24,
  parameter int Q    = 12,
  parameter int ITER = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  output logic [N-1:0] o_angle,
  output logic [N-1:0] o_mag,
  output logic         o_complete,
  output logic         o_overflow,
  output logic         o_zero
);

  localparam int W  = N + 2;
  localparam int CW = 4;
  // Angle constants are written in Q12; the scale factor keeps pi tied to Q.
  localparam logic signed [W-1:0] PI = W'(12868 * (1 << (Q - 12)));

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_POST, S_DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic signed [W-1:0] x_r, y_r, z_r;
  logic                zero_r;
  logic signed [W-1:0] x_in, y_in, x_sh, y_sh, atan_i;

  function automatic logic signed [W-1:0] sm_to_tc(input logic [N-1:0] v);
    logic signed [W-1:0] m;
    m = signed'(W'(v[N-2:0]));
    return v[N-1] ? -m : m;
  endfunction

  function automatic logic signed [W-1:0] atan_lut(input logic [CW-1:0] i);
    logic signed [W-1:0] r;
    case (i)
      4'd0:    r = W'(3217);
      4'd1:    r = W'(1899);
      4'd2:    r = W'(1003);
      4'd3:    r = W'(509);
      4'd4:    r = W'(256);
      4'd5:    r = W'(128);
      4'd6:    r = W'(64);
      4'd7:    r = W'(32);
      4'd8:    r = W'(16);
      4'd9:    r = W'(8);
      4'd10:   r = W'(4);
      4'd11:   r = W'(2);
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    x_in   = sm_to_tc(i_x);
    y_in   = sm_to_tc(i_y);
    x_sh   = x_r >>> cnt;
    y_sh   = y_r >>> cnt;
    atan_i = atan_lut(cnt);
  end

`ifdef ATAN2_MAG_OUT_EN
  localparam int PW = W + 12;
  localparam logic signed [PW-1:0] INV_K   = PW'(2487);
  localparam logic        [W-1:0]  MAG_MAX = W'((1 << (N - 1)) - 1);
  logic [W-1:0] mag_r;
`else
  assign o_mag      = '0;
  assign o_overflow = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the datapath registers are reset too, so a mid-run reset leaves no stale vector behind.
      state      <= S_IDLE;
      cnt        <= '0;
      x_r        <= '0;
      y_r        <= '0;
      z_r        <= '0;
      zero_r     <= 1'b0;
      o_angle    <= '0;
      o_zero     <= 1'b0;
      o_complete <= 1'b1;
`ifdef ATAN2_MAG_OUT_EN
      mag_r      <= '0;
      o_mag      <= '0;
      o_overflow <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            zero_r <= (x_in == '0) && (y_in == '0);
            // Left half-plane: rotate by pi so the iterations only cover +-90 degrees.
            if (x_in[W-1]) begin
              x_r <= -x_in;
              y_r <= -y_in;
              z_r <= y_in[W-1] ? -PI : PI;
            end else begin
              x_r <= x_in;
              y_r <= y_in;
              z_r <= '0;
            end
            cnt        <= '0;
            o_complete <= 1'b0;
            state      <= S_ITER;
          end
        end
        S_ITER: begin
          // NOTE: non-blocking updates make x, y and z all use the previous iteration's values.
          if (!y_r[W-1]) begin
            x_r <= x_r + y_sh;
            y_r <= y_r - x_sh;
            z_r <= z_r + atan_i;
          end else begin
            x_r <= x_r - y_sh;
            y_r <= y_r + x_sh;
            z_r <= z_r - atan_i;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
`ifdef ATAN2_MAG_OUT_EN
            state <= S_POST;
`else
            state <= S_DONE;
`endif
          end
        end
`ifdef ATAN2_MAG_OUT_EN
        S_POST: begin
          mag_r <= W'((PW'(x_r) * INV_K) >>> Q);
          state <= S_DONE;
        end
`endif
        S_DONE: begin
          o_angle <= zero_r ? '0 : {z_r[W-1], (N-1)'(z_r[W-1] ? -z_r : z_r)};
          o_zero  <= zero_r;
`ifdef ATAN2_MAG_OUT_EN
          if (mag_r > MAG_MAX) begin
            o_mag      <= N'(MAG_MAX);
            o_overflow <= 1'b1;
          end else begin
            o_mag      <= N'(mag_r);
            o_overflow <= 1'b0;
          end
`endif
          o_complete <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atan2_cordic_sn.sv
// Self-checking bench for atan2_cordic_sn: directed vector table, random vectors against a
// real-arithmetic atan2/hypot model, and hand-written busy-start and mid-run reset sequences.

module tb_atan2_cordic_sn;

  localparam int  N    = 24;
  localparam int  ITER = 12;
`ifdef ATAN2_MAG_OUT_EN
  localparam int  LAT  = ITER + 2;
`else
  localparam int  LAT  = ITER + 1;
`endif
  localparam real PI_L    = 3.14159265358979 * 4096.0;
  localparam real MAG_LIM = 8388607.0;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_start;
  logic [N-1:0] i_x;
  logic [N-1:0] i_y;
  logic [N-1:0] o_angle;
  logic [N-1:0] o_mag;
  logic         o_complete;
  logic         o_overflow;
  logic         o_zero;

  atan2_cordic_sn #(.N(N), .Q(12), .ITER(ITER)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_x        (i_x),
    .i_y        (i_y),
    .o_angle    (o_angle),
    .o_mag      (o_mag),
    .o_complete (o_complete),
    .o_overflow (o_overflow),
    .o_zero     (o_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    real          ea;
    bit           ez;
    real          em;
    int           eovf;
  } vec_t;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sm2int(input logic [N-1:0] v);
    return v[N-1] ? -int'(v[N-2:0]) : int'(v[N-2:0]);
  endfunction

  task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y);
    @(negedge i_clk);
    i_x = x;
    i_y = y;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_x = N'($urandom);
    i_y = N'($urandom);
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!o_complete && cyc < 40) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
  endtask

  // eovf: 0/1 expected overflow flag, -1 when the magnitude sits too close to the limit to call.
  task automatic check_result(input string tag, input real ea, input bit ez, input real em,
                              input int eovf, input int cyc);
    real d;
    int  ga;
    check({tag, " complete_low_cycles"}, cyc == LAT, cyc, LAT);
    ga = sm2int(o_angle);
    d  = real'(ga) - ea;
    if (d > PI_L) d = d - 2.0 * PI_L;
    else if (d < -PI_L) d = d + 2.0 * PI_L;
    check({tag, " angle"}, d <= 4.0 && d >= -4.0, ga, longint'(ea));
    check({tag, " angle_no_neg_zero"}, o_angle != 24'h800000, o_angle, 0);
    check({tag, " zero"}, o_zero == ez, o_zero, ez);
`ifdef ATAN2_MAG_OUT_EN
    if (eovf >= 0) begin
      check({tag, " overflow"}, o_overflow == eovf[0], o_overflow, eovf);
      if (eovf == 1) begin
        check({tag, " mag_sat"}, o_mag == 24'h7FFFFF, o_mag, 24'h7FFFFF);
      end else begin
        d = real'(o_mag) - em;
        check({tag, " mag"}, d <= 4.0 + em * 3.0e-4 && d >= -(4.0 + em * 3.0e-4),
              o_mag, longint'(em));
      end
    end
`else
    check({tag, " mag_tied"}, o_mag == '0, o_mag, 0);
    check({tag, " overflow_tied"}, o_overflow == 1'b0, o_overflow, 0);
`endif
  endtask

  initial begin
    vec_t         vecs[8];
    int           cyc;
    logic [N-1:0] rx, ry;
    int           mx, my;
    real          xr, yr, ea, em;
    int           eovf;

    vecs[0] = '{24'h001000, 24'h001000,  3217.0, 1'b0, 5793.0, 0};
    vecs[1] = '{24'h801000, 24'h800000, 12868.0, 1'b0, 4096.0, 0};
    vecs[2] = '{24'h000000, 24'h802000, -6434.0, 1'b0, 8192.0, 0};
    vecs[3] = '{24'h000000, 24'h000000,     0.0, 1'b1,    0.0, 0};
    vecs[4] = '{24'h7FF000, 24'h7FF000,  3217.0, 1'b0,    0.0, 1};
    vecs[5] = '{24'h801000, 24'h801000, -9651.0, 1'b0, 5793.0, 0};
    vecs[6] = '{24'h800000, 24'h800000,     0.0, 1'b1,    0.0, 0};
    vecs[7] = '{24'h001000, 24'h800000,     0.0, 1'b0, 4096.0, 0};

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_x     = '0;
    i_y     = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset complete", o_complete == 1'b1, o_complete, 1);
    check("reset angle", o_angle == '0, o_angle, 0);
    check("reset mag", o_mag == '0, o_mag, 0);
    check("reset overflow", o_overflow == 1'b0, o_overflow, 0);
    check("reset zero", o_zero == 1'b0, o_zero, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].x, vecs[i].y);
      wait_done(0, cyc);
      check_result($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ez, vecs[i].em, vecs[i].eovf, cyc);
      if (i == 1) check("vec1 angle_sign", o_angle[N-1] == 1'b0, o_angle[N-1], 0);
    end

    for (int i = 0; i < 40; i++) begin
      mx = int'($urandom_range(0, (1 << 23) - 1));
      my = int'($urandom_range(0, (1 << 23) - 1));
      if (mx < (1 << 18) && my < (1 << 18)) mx = mx + (1 << 18);
      rx = {1'($urandom_range(0, 1)), 23'(mx)};
      ry = {1'($urandom_range(0, 1)), 23'(my)};
      xr = real'(sm2int(rx));
      yr = real'(sm2int(ry));
      ea = $atan2(yr, xr) * 4096.0;
      em = $sqrt(xr * xr + yr * yr) * (2487.0 / 4096.0) * 1.646760258;
      if (em > MAG_LIM * 1.0005) eovf = 1;
      else if (em < MAG_LIM * 0.9995) eovf = 0;
      else eovf = -1;
      start_op(rx, ry);
      wait_done(0, cyc);
      check_result($sformatf("rnd%0d", i), ea, 1'b0, em, eovf, cyc);
    end

    // A start pulse while busy must neither restart nor re-sample the inputs.
    start_op(24'h001000, 24'h001000);
    cyc = 0;
    repeat (3) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
    @(negedge i_clk);
    i_x = 24'h802000;
    i_y = 24'h000000;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    cyc++;
    i_start = 1'b0;
    wait_done(cyc, cyc);
    check_result("busy_start", 3217.0, 1'b0, 5793.0, 0, cyc);
    repeat (3) @(posedge i_clk);
    #1;
    check("busy_start stays idle", o_complete == 1'b1, o_complete, 1);

    // Mid-iteration reset: outputs hold until then, reset clears them, restart is clean.
    start_op(24'h801000, 24'h801000);
    repeat (2) @(posedge i_clk);
    #1;
    check("hold busy", o_complete == 1'b0, o_complete, 0);
    check("hold angle", sm2int(o_angle) >= 3213 && sm2int(o_angle) <= 3221, sm2int(o_angle), 3217);
    repeat (3) @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("midrst complete", o_complete == 1'b1, o_complete, 1);
    check("midrst angle", o_angle == '0, o_angle, 0);
    check("midrst mag", o_mag == '0, o_mag, 0);
    check("midrst overflow", o_overflow == 1'b0, o_overflow, 0);
    check("midrst zero", o_zero == 1'b0, o_zero, 0);
    @(posedge i_clk);
    #1;
    check("midrst complete held", o_complete == 1'b1, o_complete, 1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    start_op(24'h001000, 24'h000000);
    wait_done(0, cyc);
    check_result("restart", 0.0, 1'b0, 4096.0, 0, cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atan2_cordic_sn.md
# atan2_cordic_sn

Iterative CORDIC vectoring engine: the inverse of the rotor-model sine path. It takes a sign-magnitude Q12.12 vector (x, y) and returns its angle in radians, in the same sign-magnitude Q12.12 format the sine calculator consumes. It also optionally returns the vector magnitude. It sits in the rotor/vector-control model, where it recovers rotor angle from the α/β components, and uses the same start/complete handshake as the sequential divider.

## Interface

**Parameters**
- `N`, 24 — word width, sign-magnitude (bit N-1 is the sign, bits N-2:0 are the magnitude).
- `Q`, 12 — fraction bits. Only 12 is supported; the arctan table constants are Q12.
- `ITER`, 12 — number of CORDIC iterations. Legal range 4..12.

**Ports**
- `i_clk`  in  1 — clock. The block uses this single clock.
- `i_rst_n`  in  1 — asynchronous, active-low reset.
- `i_start`  in  1 — start request. Sampled only while idle.
- `i_x`  in  N — x component, sign-magnitude Q12.12.
- `i_y`  in  N — y component, sign-magnitude Q12.12.
- `o_angle`  out  N — atan2(y, x) in radians, sign-magnitude Q12.12, range [-π, π].
- `o_mag`  out  N — sqrt(x²+y²), sign bit always 0.
- `o_complete`  out  1 — high when idle or result valid; low while busy.
- `o_overflow`  out  1 — magnitude saturated.
- `o_zero`  out  1 — input vector was (0, 0).

## Operation

**States**
- IDLE: if `i_start`=1, go to ITER; otherwise stay.
- ITER: runs for `ITER` cycles.
- POST: only present when the magnitude feature is compiled in.
- DONE: writes the outputs, then returns to IDLE.

**PREP (on start acceptance)**
- `i_x` and `i_y` are converted to two's complement, internal width W = N+2.
- A magnitude of zero counts as non-negative, whatever its sign bit.
- Quadrant fold when x<0:
  - x ← -x and y ← -y.
  - z0 = +π (12868) if the original y ≥ 0, else -π.
- Otherwise z0 = 0.

**ITER (iteration i = 0..ITER-1, one per cycle)**
- If y ≥ 0: x += y>>>i; y -= x>>>i; z += atan_i.
- Else: x -= y>>>i; y += x>>>i; z -= atan_i.
- Shifts are arithmetic, and all updates use the old values.
- atan table (Q12): 3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2.

**POST**
- mag = x × 2487 (1/K, Q12), truncated >> 12.

**DONE (output conversion)**
- z is converted to sign-magnitude.
- A zero magnitude always gets sign 0; no negative zero is ever output.
- If mag exceeds 2^(N-1)-1: `o_mag` = 0x7FFFFF and `o_overflow`=1.
- `o_zero`=1 iff both input magnitudes were 0. In that case `o_angle`=0 and `o_mag`=0.

**Boundary rules**
- `i_start` while busy is ignored; the inputs are not re-sampled.
- The outputs hold their last result until the next DONE.
- Reset at any point, including mid-iteration, does all of the following:
  - state → IDLE;
  - `o_complete`=1;
  - all other outputs = 0;
  - all internal registers cleared.

## Timing

- Edge 0: `i_start`=1 sampled in IDLE. Inputs are folded and registered, and `o_complete` goes to 0 after this edge.
- Edges 1..ITER: one iteration per edge.
- Output edge, with `ATAN2_MAG_OUT_EN`: edge ITER+2, i.e. after the POST multiply register at edge ITER+1.
- Output edge, without the macro: edge ITER+1.
- On the output edge, all outputs update together and `o_complete` returns to 1.
- `o_complete` low time: ITER+2 cycles with the macro, ITER+1 without (ITER=12 → 14 or 13).
- A new start is accepted on the first edge with `o_complete`=1, so back-to-back operation is possible.
- Angle accuracy: ±4 LSB for ITER=12.

## Configuration

- `ATAN2_MAG_OUT_EN` defined:
  - The POST state and the 1/K multiplier are built.
  - `o_mag` and `o_overflow` are live.
- Not defined:
  - POST and the multiplier are removed; latency drops by one cycle.
  - `o_mag` and `o_overflow` are tied to 0.
  - The angle result is bit-identical to the defined case.

## Test plan

- x=0x001000, y=0x001000 → `o_angle`=0x000C91 ±4. With the macro, `o_mag`=5793 ±4. `o_complete` low for exactly 14 cycles.
- x=0x801000 (-1.0), y=0x800000 (negative zero) → `o_angle`=0x003244 (+π) ±4, sign bit 0.
- x=0, y=0x802000 (-2.0) → `o_angle`=0x801922 (-π/2) ±4, `o_mag`=8192 ±4.
- x=0, y=0 → `o_angle`=0x000000, `o_mag`=0, `o_zero`=1, `o_overflow`=0.
- x=y=0x7FF000 → `o_overflow`=1, `o_mag`=0x7FFFFF, `o_angle`=0x000C91 ±4.
- Sequence: start, pulse `i_start` again at iteration 3, pull `i_rst_n` low at iteration 5, then start again with x=0x001000, y=0. Required:
  - the second `i_start` has no effect;
  - during reset, `o_complete`=1 and all outputs are 0;
  - the restarted run gives `o_angle`=0 ±4.
